// File: rtl/multicycle_sequencer_if.sv
// Memory-side handshake bundle for multicycle_sequencer.
// The instruction and data ports each use a req/ready pair.
interface multicycle_sequencer_if #(
  parameter int PC_W = 5
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            imem_ready;
  logic            dmem_req;
  logic            dmem_we;
  logic [15:0]     dmem_addr;
  logic [15:0]     dmem_wdata;
  logic [15:0]     dmem_rdata;
  logic            dmem_ready;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_ready, dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_ready, dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB controller with req/ready memory handshakes.
// Optional handshake timeout with sticky bus_error and HALT: define MSEQ_TIMEOUT_EN.
module multicycle_sequencer #(
  parameter int PC_W           = 5,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  multicycle_sequencer_if.master mem,
  output logic [15:0]            ir,
  input  logic                   dec_reg_write,
  input  logic                   dec_mem_read,
  input  logic                   dec_mem_write,
  input  logic                   dec_branch,
  input  logic                   dec_jump,
  input  logic                   alu_zero,
  input  logic [15:0]            alu_result,
  input  logic [15:0]            read_data2,
  input  logic [15:0]            read_data1,
  output logic                   rf_we,
  output logic                   wb_sel,
  output logic [15:0]            mdr,
  output logic [PC_W-1:0]        pc,
  output logic [2:0]             state,
  output logic                   bus_error
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  logic [2:0]      state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [15:0]     ir_reg;
  logic [15:0]     mdr_reg;
  logic            zero_q;
  logic [PC_W-1:0] tgt_q;
  logic [15:0]     addr_q;
  logic [15:0]     wdata_q;
  logic            imem_req_int;
  logic            dmem_req_int;
  logic            timeout_hit;

  // Request is held off while reset is asserted so nothing is issued mid-reset.
  assign imem_req_int = (state_reg == S_FETCH) && run && reset;
  assign dmem_req_int = (state_reg == S_MEM);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:   if (imem_req_int && mem.imem_ready) state_next = S_DECODE;
      S_DECODE:  state_next = S_EXECUTE;
      S_EXECUTE: state_next = (dec_mem_read || dec_mem_write) ? S_MEM : S_WB;
      S_MEM:     if (mem.dmem_ready) state_next = S_WB;
      S_WB:      state_next = S_FETCH;
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_FETCH;
    endcase
    if (timeout_hit) state_next = S_HALT;
  end

  // Branch wins over jump; everything else advances sequentially with wrap.
  always_comb begin
    pc_next = pc_reg + PC_W'(1);
    if (dec_branch && zero_q) pc_next = pc_reg + PC_W'(ir_reg[6:0]);
    else if (dec_jump)        pc_next = tgt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_FETCH;
      pc_reg    <= '0;
      ir_reg    <= '0;
      mdr_reg   <= '0;
      zero_q    <= 1'b0;
      tgt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_FETCH && state_next == S_DECODE) ir_reg <= mem.imem_rdata;
      if (state_reg == S_EXECUTE) begin
        zero_q  <= alu_zero;
        tgt_q   <= read_data1[PC_W-1:0];
        addr_q  <= alu_result;
        wdata_q <= read_data2;
      end
      if (state_reg == S_MEM && state_next == S_WB && dec_mem_read) mdr_reg <= mem.dmem_rdata;
      if (state_reg == S_WB) pc_reg <= pc_next;
    end
  end

`ifdef MSEQ_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;

  logic [CNT_W-1:0] stall_cnt_reg;
  logic             bus_error_reg;
  logic             stall;

  assign stall       = (imem_req_int && !mem.imem_ready) || (dmem_req_int && !mem.dmem_ready);
  assign timeout_hit = ((state_reg == S_FETCH) || (state_reg == S_MEM)) &&
                       (stall_cnt_reg == CNT_W'(TIMEOUT_CYCLES));

  // Counter restarts on every state change so each handshake gets a fresh budget.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
      bus_error_reg <= 1'b0;
    end else begin
      if (state_next != state_reg) stall_cnt_reg <= '0;
      else if (stall)              stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (timeout_hit) bus_error_reg <= 1'b1;
    end
  end

  assign bus_error = bus_error_reg;
`else
  // Without the timeout the parameter only documents the interface.
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign bus_error   = 1'b0;
`endif

  generate
    if (PC_W < 16) begin : g_rd1_unused
      logic unused_rd1;
      assign unused_rd1 = ^read_data1[15:PC_W];
    end
  endgenerate

  assign mem.imem_req   = imem_req_int;
  assign mem.imem_addr  = pc_reg;
  assign mem.dmem_req   = dmem_req_int;
  assign mem.dmem_we    = dmem_req_int && dec_mem_write && !dec_mem_read;
  assign mem.dmem_addr  = addr_q;
  assign mem.dmem_wdata = wdata_q;

  assign rf_we  = (state_reg == S_WB) && dec_reg_write;
  assign wb_sel = (state_reg == S_WB) && dec_mem_read;
  assign ir     = ir_reg;
  assign mdr    = mdr_reg;
  assign pc     = pc_reg;
  assign state  = state_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed-vector bench for multicycle_sequencer; one line per checked transaction.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [15:0] ir;
  logic        dec_reg_write = 1'b0, dec_mem_read = 1'b0, dec_mem_write = 1'b0;
  logic        dec_branch = 1'b0, dec_jump = 1'b0, alu_zero = 1'b0;
  logic [15:0] alu_result = '0, read_data2 = '0, read_data1 = '0;
  logic        rf_we, wb_sel, bus_error;
  logic [15:0] mdr;
  logic [4:0]  pc;
  logic [2:0]  state;

  int total_cnt = 0;
  int bad_cnt   = 0;

  multicycle_sequencer_if #(.PC_W(5)) mem_if ();

  multicycle_sequencer #(.PC_W(5), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .run(run), .mem(mem_if),
    .ir(ir),
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_branch(dec_branch), .dec_jump(dec_jump),
    .alu_zero(alu_zero), .alu_result(alu_result),
    .read_data2(read_data2), .read_data1(read_data1),
    .rf_we(rf_we), .wb_sel(wb_sel), .mdr(mdr), .pc(pc), .state(state),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs a non-memory instruction from FETCH back to the next FETCH (4 cycles).
  task automatic exec_simple(input logic [15:0] instr);
    mem_if.imem_rdata = instr;
    mem_if.imem_ready = 1'b1;
    step();
    mem_if.imem_ready = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic clear_dec();
    dec_reg_write = 1'b0; dec_mem_read = 1'b0; dec_mem_write = 1'b0;
    dec_branch = 1'b0; dec_jump = 1'b0; alu_zero = 1'b0;
  endtask

  initial begin
    mem_if.imem_rdata = '0; mem_if.imem_ready = 1'b0;
    mem_if.dmem_rdata = '0; mem_if.dmem_ready = 1'b0;

    // Reset held for two edges with run already high
    @(negedge clk);
    reset = 1'b0; run = 1'b1;
    step(); step();
    chk_val("rst_pc", pc, 0);
    chk_val("rst_state", state, 0);
    chk_val("rst_imem_req", mem_if.imem_req, 0);
    chk_val("rst_bus_error", bus_error, 0);
    reset = 1'b1;
    #1;
    chk_val("post_rst_imem_req", mem_if.imem_req, 1);
    chk_val("post_rst_imem_addr", mem_if.imem_addr, 0);
    @(negedge clk);

    // ALU instruction, zero-wait fetch: rf_we only in the 4th cycle
    dec_reg_write = 1'b1;
    mem_if.imem_rdata = 16'h1111; mem_if.imem_ready = 1'b1;
    #1;
    chk_val("alu_c1_rf_we", rf_we, 0);
    step();
    mem_if.imem_ready = 1'b0;
    chk_val("alu_c2_ir", ir, 16'h1111);
    chk_val("alu_c2_state", state, 1);
    chk_val("alu_c2_rf_we", rf_we, 0);
    step();
    chk_val("alu_c3_state", state, 2);
    chk_val("alu_c3_rf_we", rf_we, 0);
    step();
    chk_val("alu_c4_state", state, 4);
    chk_val("alu_c4_rf_we", rf_we, 1);
    chk_val("alu_c4_wb_sel", wb_sel, 0);
    step();
    chk_val("alu_next_rf_we", rf_we, 0);
    chk_val("alu_pc", pc, 1);
    chk_val("alu_next_state", state, 0);

    // Load with three wait cycles on dmem_ready: 8-cycle instruction
    dec_mem_read = 1'b1;
    alu_result = 16'h0012; mem_if.dmem_rdata = 16'hBEEF; mem_if.dmem_ready = 1'b0;
    mem_if.imem_rdata = 16'h2222; mem_if.imem_ready = 1'b1;
    step();
    mem_if.imem_ready = 1'b0;
    step();
    step();
    alu_result = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      chk_val($sformatf("ld_mem%0d_state", i), state, 3);
      chk_val($sformatf("ld_mem%0d_req", i), mem_if.dmem_req, 1);
      chk_val($sformatf("ld_mem%0d_addr", i), mem_if.dmem_addr, 16'h0012);
      chk_val($sformatf("ld_mem%0d_we", i), mem_if.dmem_we, 0);
      if (i == 3) mem_if.dmem_ready = 1'b1;
      step();
    end
    mem_if.dmem_ready = 1'b0;
    chk_val("ld_wb_state", state, 4);
    chk_val("ld_mdr", mdr, 16'hBEEF);
    chk_val("ld_wb_sel", wb_sel, 1);
    chk_val("ld_rf_we", rf_we, 1);
    step();
    chk_val("ld_pc", pc, 2);
    chk_val("ld_next_state", state, 0);
    clear_dec();

    // Store with zero-wait data memory: 5 cycles, no register write
    dec_mem_write = 1'b1;
    alu_result = 16'h0040; read_data2 = 16'hA5A5; mem_if.dmem_ready = 1'b1;
    mem_if.imem_rdata = 16'h3333; mem_if.imem_ready = 1'b1;
    step();
    mem_if.imem_ready = 1'b0;
    step();
    step();
    chk_val("st_state", state, 3);
    chk_val("st_we", mem_if.dmem_we, 1);
    chk_val("st_addr", mem_if.dmem_addr, 16'h0040);
    chk_val("st_wdata", mem_if.dmem_wdata, 16'hA5A5);
    step();
    chk_val("st_wb_state", state, 4);
    chk_val("st_rf_we", rf_we, 0);
    chk_val("st_wb_sel", wb_sel, 0);
    step();
    chk_val("st_pc", pc, 3);
    mem_if.dmem_ready = 1'b0;
    clear_dec();

    // Branch / jump PC arithmetic
    dec_jump = 1'b1; read_data1 = 16'h001E;
    exec_simple(16'h0000);
    chk_val("jmp_pc30", pc, 30);
    dec_jump = 1'b0; dec_branch = 1'b1; alu_zero = 1'b1;
    exec_simple(16'hFF83);
    chk_val("br_taken_wrap_pc", pc, 1);
    dec_branch = 1'b0; dec_jump = 1'b1; alu_zero = 1'b0;
    exec_simple(16'h0000);
    chk_val("jmp_pc30_again", pc, 30);
    dec_jump = 1'b0; dec_branch = 1'b1;
    exec_simple(16'h0003);
    chk_val("br_not_taken_pc", pc, 31);
    dec_branch = 1'b0;
    exec_simple(16'h0000);
    chk_val("seq_wrap_pc", pc, 0);
    dec_branch = 1'b1; dec_jump = 1'b1; read_data1 = 16'h0007;
    exec_simple(16'h0003);
    chk_val("br_jmp_pc", pc, 7);
    clear_dec();

    // Reset asserted during a stalled MEM access
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    dec_mem_read = 1'b1; dec_reg_write = 1'b1;
    alu_result = 16'h0012; mem_if.dmem_rdata = 16'hCAFE; mem_if.dmem_ready = 1'b0;
    mem_if.imem_rdata = 16'h4444; mem_if.imem_ready = 1'b1;
    step();
    mem_if.imem_ready = 1'b0;
    step();
    step();
    chk_val("mr_state_mem", state, 3);
    chk_val("mr_req_before", mem_if.dmem_req, 1);
    reset = 1'b0;
    step();
    chk_val("mr_req_dropped", mem_if.dmem_req, 0);
    chk_val("mr_state", state, 0);
    chk_val("mr_mdr", mdr, 0);
    chk_val("mr_rf_we", rf_we, 0);
    step();
    chk_val("mr_rf_we_hold", rf_we, 0);
    chk_val("mr_pc", pc, 0);
    reset = 1'b1;
    clear_dec();

`ifdef MSEQ_TIMEOUT_EN
    // Fetch stalls forever: HALT after 15 stall cycles
    repeat (15) step();
    chk_val("to_before_bus_error", bus_error, 0);
    chk_val("to_before_state", state, 0);
    chk_val("to_before_req", mem_if.imem_req, 1);
    step();
    chk_val("to_bus_error", bus_error, 1);
    chk_val("to_state_halt", state, 5);
    chk_val("to_req_dropped", mem_if.imem_req, 0);
    mem_if.imem_ready = 1'b1;
    step(); step();
    chk_val("to_halt_stays", state, 5);
    chk_val("to_halt_req", mem_if.imem_req, 0);
    chk_val("to_halt_pc", pc, 0);
    mem_if.imem_ready = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_val("to_rst_bus_error", bus_error, 0);
    chk_val("to_rst_state", state, 0);
`else
    // Without the timeout a stalled fetch simply waits
    repeat (20) step();
    chk_val("stall_bus_error", bus_error, 0);
    chk_val("stall_state", state, 0);
    chk_val("stall_req", mem_if.imem_req, 1);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle controller that sequences the 16-bit datapath (instruction decoder, register file, ALU) through fetch/decode/execute/memory/writeback states. It replaces the single-cycle ROM fetch with req/ready handshakes to instruction and data memory, so memories with variable latency can be used. It owns the program counter, the instruction register and the register-file write strobe.

Parameters:
PC_W, 5, program counter / instruction address width
TIMEOUT_CYCLES, 15, stall cycles tolerated on a memory handshake (used only with the optional feature)

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
run  input  1  start enable; FETCH issues a request only when run=1
imem_req  output  1  instruction fetch request
imem_addr  output  PC_W  fetch address (= pc)
imem_rdata  input  16  fetched instruction
imem_ready  input  1  fetch complete; rdata valid this cycle
ir  output  16  instruction register; feeds the decoder and register-file addresses
dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump  input  1 each  decoder controls for ir
alu_zero  input  1  ALU zero flag
alu_result  input  16  ALU result; also the data address
read_data2  input  16  store data
read_data1  input  16  jump target source
dmem_req  output  1  data access request
dmem_we  output  1  1=store, 0=load
dmem_addr  output  16  data address
dmem_wdata  output  16  store data
dmem_rdata  input  16  load data
dmem_ready  input  1  data access complete
rf_we  output  1  register-file write strobe
wb_sel  output  1  0=ALU result, 1=mdr
mdr  output  16  captured load data
pc  output  PC_W  program counter
state  output  3  current state encoding
bus_error  output  1  sticky handshake timeout flag

Behaviour:
- States (encoding): FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5.
- Reset (reset=0 at an edge): state=FETCH; pc, ir, mdr=0; all req/we/rf_we/wb_sel=0; bus_error=0. Reset overrides everything, including an in-flight handshake; req drops on that edge.
- FETCH:
  - imem_req=run, imem_addr=pc.
  - On an edge with req and imem_ready both high: ir<=imem_rdata, go to DECODE.
  - Otherwise hold; req and addr stay stable until ready.
  - ready without req is ignored.
- DECODE: one cycle; decoder outputs settle from ir. Go to EXECUTE.
- EXECUTE: one cycle. Latch:
  - zero_q<=alu_zero
  - tgt_q<=read_data1[PC_W-1:0]
  - addr_q<=alu_result
  - wdata_q<=read_data2
  - Next state: MEM if dec_mem_read or dec_mem_write, else WB.
- MEM:
  - dmem_req=1, dmem_addr=addr_q, dmem_wdata=wdata_q.
  - dmem_we=dec_mem_write & ~dec_mem_read; read wins if both are set.
  - On req&ready: for a load, mdr<=dmem_rdata. Go to WB.
- WB: one cycle.
  - rf_we=dec_reg_write.
  - wb_sel=1 if the instruction was a load, else 0.
  - PC update on exit to FETCH, in priority order:
    - dec_branch&zero_q: pc<=pc+ir[6:0], truncated to PC_W (modulo wrap).
    - else dec_jump: pc<=tgt_q.
    - else pc<=pc+1, wrapping from 2^PC_W-1 to 0.
- rf_we is asserted only in WB; it is a single-cycle pulse per instruction.
- Latency with zero-wait memories:
  - ALU/branch/jump instruction: 4 cycles.
  - Load/store: 5 cycles.
  - Each wait cycle on ready adds 1.
- run=0 only gates new fetches; an instruction already past FETCH completes.
- Outputs are registered or decoded from state only; none depends combinationally on ready.

Optional Feature:
Macro MSEQ_TIMEOUT_EN.
- Defined:
  - A 4+ bit stall counter clears on state entry and increments each cycle req=1 & ready=0.
  - When the count reaches TIMEOUT_CYCLES, the next edge drops req, sets bus_error=1 and enters HALT.
  - HALT: all requests 0, rf_we 0, pc frozen; left only by reset.
- Not defined: no counter, bus_error tied 0, HALT unreachable, and handshakes wait indefinitely.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, run=1 -> pc=0, state=0, imem_req=0 during reset; imem_req=1 in the first cycle after release.
2. ALU instruction, ready tied 1, dec_reg_write=1 -> rf_we high exactly in cycle 4, wb_sel=0; pc 0->1.
3. Load, dmem_ready delayed 3 cycles, alu_result=16'h0012, dmem_rdata=16'hBEEF -> dmem_addr=0x0012 stable for 4 cycles, we=0, mdr=0xBEEF, wb_sel=1, 8-cycle instruction.
4. Branch with pc=30, ir[6:0]=3, alu_zero=1 -> pc=1 (wrap); same with alu_zero=0 -> pc=31. Branch+jump with zero=0, read_data1=0x0007 -> pc=7.
5. Assert reset=0 during MEM with ready low -> dmem_req=0 on the next edge, state=FETCH, mdr unchanged at 0, no rf_we.
6. With MSEQ_TIMEOUT_EN, imem_ready held 0 -> after 15 stall cycles bus_error=1, state=HALT, imem_req=0 permanently until reset.
